// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: active-low glyphs,
// scanner state encoding and the hex-to-glyph mapping.
package seg_pkg;

  // Cathode order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    // NOTE: assign a default before the case so every path drives the
    // result; in combinational logic a missed path would infer a latch.
    hex_to_seg = SEG_OFF;
    case (hex)
      4'h0: hex_to_seg = SEG_0;
      4'h1: hex_to_seg = SEG_1;
      4'h2: hex_to_seg = SEG_2;
      4'h3: hex_to_seg = SEG_3;
      4'h4: hex_to_seg = SEG_4;
      4'h5: hex_to_seg = SEG_5;
      4'h6: hex_to_seg = SEG_6;
      4'h7: hex_to_seg = SEG_7;
      4'h8: hex_to_seg = SEG_8;
      4'h9: hex_to_seg = SEG_9;
      4'hA: hex_to_seg = SEG_A;
      4'hB: hex_to_seg = SEG_B;
      4'hC: hex_to_seg = SEG_C;
      4'hD: hex_to_seg = SEG_D;
      4'hE: hex_to_seg = SEG_E;
      4'hF: hex_to_seg = SEG_F;
      default: hex_to_seg = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex digit to active-low seven-segment glyph.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_hex);

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed display scanner: strobe synchronizer, digit index,
// frame-latched shadow data, anode blanking FSM and registered drivers.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [7:0]      CNT_LOAD = 8'(BLANK_CYCLES - 1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_sync3;
  logic                w_step;
  logic                w_wrap;

  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_sh_digits;
  logic [DIGITS-1:0]   r_sh_blank;
  logic [DIGITS-1:0]   r_sh_dp;
  logic                r_frame_pend;

  scan_state_t         r_state;
  logic [7:0]          r_cnt;
  logic                r_nodigit;

  logic [3:0]          w_hex;
  logic [6:0]          w_glyph;
  logic [DIGITS-1:0]   w_an_show;

  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;
  logic                r_dp_n;
  logic                r_frame_done;

  // sclk is asynchronous: two flops for metastability, a third for the edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs, independent of statement order.
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= sclk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_step = r_sync2 & ~r_sync3;
  assign w_wrap = (r_idx == IDX_LAST);

  // Index counter and frame latch; shadow data is only refreshed on a wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx        <= IDX_LAST;
      r_sh_digits  <= '0;
      r_sh_blank   <= '1;
      r_sh_dp      <= '0;
      r_frame_pend <= 1'b0;
    end else begin
      r_frame_pend <= w_step & w_wrap;
      if (w_step) begin
        if (w_wrap) begin
          r_idx       <= '0;
          r_sh_digits <= digits;
          r_sh_blank  <= blank;
          r_sh_dp     <= dp;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign w_hex     = r_sh_digits[{r_idx, 2'b00} +: 4];
  assign w_an_show = ~(DIGITS'(1) << r_idx);

  seg_decoder u_decoder (
    .i_hex (w_hex),
    .o_seg (w_glyph)
  );

  // Blanking FSM with the anode driver registered alongside it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= BLANK;
      r_cnt     <= '0;
      r_nodigit <= 1'b1;
      r_an      <= '1;
    end else begin
      r_an <= (r_state == SHOW) ? w_an_show : '1;
      if (w_step) begin
        // A step always restarts the full gap, even mid-blank.
        r_state   <= BLANK;
        r_cnt     <= CNT_LOAD;
        r_nodigit <= 1'b0;
      end else begin
        case (r_state)
          BLANK: begin
            if (r_cnt != 8'd0) begin
              r_cnt <= r_cnt - 8'd1;
            end else if (!r_nodigit) begin
              r_state <= SHOW;
            end
          end
          SHOW:    r_state <= SHOW;
          default: r_state <= BLANK;
        endcase
      end
    end
  end

  // Cathodes follow idx/shadow, which only move on a step, so they settle
  // in the first blanking cycle while the anodes are still off.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_seg        <= SEG_OFF;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_frame_pend;
      if (r_sh_blank[r_idx]) begin
        r_seg  <= SEG_OFF;
        r_dp_n <= 1'b1;
      end else begin
        r_seg  <= w_glyph;
        r_dp_n <= ~r_sh_dp[r_idx];
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: directed scan sequences, a glyph/blank/dp
// vector table and randomized strobes against a frame-level reference model.
module tb_seg_scan;

  localparam int D = 4;
  localparam int B = 16;

  logic           clk;
  logic           reset;
  logic           sclk;
  logic [4*D-1:0] digits;
  logic [D-1:0]   blank;
  logic [D-1:0]   dp;
  logic [D-1:0]   an;
  logic [6:0]     seg;
  logic           dp_n;
  logic           frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] hex;
    logic       blk;
    logic       dpb;
    logic [6:0] exp_seg;
    logic       exp_dpn;
  } vec_t;

  vec_t       vecs[16];
  logic [6:0] glyph[16];

  // Reference model state: digit index and latched frame.
  int             m_idx;
  logic [4*D-1:0] m_digits;
  logic [D-1:0]   m_blank;
  logic [D-1:0]   m_dp;

  seg_scan #(.DIGITS(D), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .digits     (digits),
    .blank      (blank),
    .dp         (dp),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " an"}, 32'(an), 32'hF);
    check({nm, " seg"}, 32'(seg), 32'h7F);
    check({nm, " dp_n"}, 32'(dp_n), 32'h1);
    check({nm, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Returns just after the edge at which the new digit's outputs appear.
  task automatic strobe();
    sclk = 1'b1;
    tick();
    tick();
    sclk = 1'b0;
    tick();
    tick();
  endtask

  task automatic step_expect(input logic [3:0] exp_an, input logic [6:0] exp_seg,
                             input logic exp_dpn, input logic exp_fd, input string nm);
    int gap;
    logic extra_fd;
    strobe();
    check({nm, " frame_done"}, 32'(frame_done), 32'(exp_fd));
    check({nm, " an_blank"}, 32'(an), 32'hF);
    check({nm, " seg"}, 32'(seg), 32'(exp_seg));
    check({nm, " dp_n"}, 32'(dp_n), 32'(exp_dpn));
    gap = 1;
    extra_fd = 1'b0;
    while (gap < 300) begin
      tick();
      if (frame_done) extra_fd = 1'b1;
      if (an != 4'hF) break;
      gap++;
    end
    check({nm, " gap"}, 32'(gap), 32'(B));
    check({nm, " fd_width"}, 32'(extra_fd), 32'h0);
    check({nm, " an_show"}, 32'(an), 32'(exp_an));
    check({nm, " seg_hold"}, 32'(seg), 32'(exp_seg));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sclk  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    m_idx    = D - 1;
    m_digits = '0;
    m_blank  = '1;
    m_dp     = '0;
  endtask

  task automatic model_step(output logic [3:0] e_an, output logic [6:0] e_seg,
                            output logic e_dpn, output logic e_fd);
    logic [3:0] h;
    m_idx = (m_idx + 1) % D;
    e_fd  = (m_idx == 0);
    if (e_fd) begin
      m_digits = digits;
      m_blank  = blank;
      m_dp     = dp;
    end
    h     = m_digits[4*m_idx +: 4];
    e_an  = ~(4'(1) << m_idx);
    e_seg = m_blank[m_idx] ? 7'h7F : glyph[h];
    e_dpn = m_blank[m_idx] ? 1'b1 : ~m_dp[m_idx];
  endtask

  initial begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dpn;
    logic       e_fd;
    logic [3:0] one_hot;

    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0]  = '{4'h0, 1'b0, 1'b0, 7'h40, 1'b1};
    vecs[1]  = '{4'h1, 1'b0, 1'b1, 7'h79, 1'b0};
    vecs[2]  = '{4'h2, 1'b0, 1'b0, 7'h24, 1'b1};
    vecs[3]  = '{4'h3, 1'b1, 1'b1, 7'h7F, 1'b1};
    vecs[4]  = '{4'h4, 1'b0, 1'b0, 7'h19, 1'b1};
    vecs[5]  = '{4'h5, 1'b0, 1'b0, 7'h12, 1'b1};
    vecs[6]  = '{4'h6, 1'b0, 1'b1, 7'h02, 1'b0};
    vecs[7]  = '{4'h7, 1'b0, 1'b0, 7'h78, 1'b1};
    vecs[8]  = '{4'h8, 1'b0, 1'b0, 7'h00, 1'b1};
    vecs[9]  = '{4'h9, 1'b1, 1'b0, 7'h7F, 1'b1};
    vecs[10] = '{4'hA, 1'b0, 1'b0, 7'h08, 1'b1};
    vecs[11] = '{4'hB, 1'b0, 1'b1, 7'h03, 1'b0};
    vecs[12] = '{4'hC, 1'b0, 1'b0, 7'h46, 1'b1};
    vecs[13] = '{4'hD, 1'b0, 1'b0, 7'h21, 1'b1};
    vecs[14] = '{4'hE, 1'b1, 1'b1, 7'h7F, 1'b1};
    vecs[15] = '{4'hF, 1'b0, 1'b0, 7'h0E, 1'b1};

    // Reset hold with a toggling strobe.
    reset  = 1'b0;
    sclk   = 1'b0;
    digits = 16'h1234;
    blank  = '0;
    dp     = '0;
    for (int i = 0; i < 5; i++) begin
      sclk = ~sclk;
      tick();
      check_reset_outputs($sformatf("reset_hold%0d", i));
    end
    sclk = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    check_reset_outputs("post_reset");

    // First frame, full scan and frame latch.
    step_expect(4'b1110, 7'h19, 1'b1, 1'b1, "first_d0");
    step_expect(4'b1101, 7'h30, 1'b1, 1'b0, "scan_d1");
    digits = 16'hABCD;
    step_expect(4'b1011, 7'h24, 1'b1, 1'b0, "latch_d2");
    step_expect(4'b0111, 7'h79, 1'b1, 1'b0, "latch_d3");
    step_expect(4'b1110, 7'h21, 1'b1, 1'b1, "wrap_d0");

    // Blank and decimal point, visible only after the next wrap.
    blank = 4'b0010;
    dp    = 4'b0100;
    step_expect(4'b1101, 7'h46, 1'b1, 1'b0, "old_d1");
    step_expect(4'b1011, 7'h03, 1'b1, 1'b0, "old_d2");
    step_expect(4'b0111, 7'h08, 1'b1, 1'b0, "old_d3");
    step_expect(4'b1110, 7'h21, 1'b1, 1'b1, "bdp_d0");
    step_expect(4'b1101, 7'h7F, 1'b1, 1'b0, "blank_d1");
    step_expect(4'b1011, 7'h03, 1'b0, 1'b0, "dp_d2");
    step_expect(4'b0111, 7'h08, 1'b1, 1'b0, "bdp_d3");

    // Glyph/blank/dp table, one frame per group of four entries.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < D; i++) begin
        digits[4*i +: 4] = vecs[4*f+i].hex;
        blank[i]         = vecs[4*f+i].blk;
        dp[i]            = vecs[4*f+i].dpb;
      end
      for (int i = 0; i < D; i++) begin
        one_hot = 4'b0001 << i;
        step_expect(~one_hot, vecs[4*f+i].exp_seg, vecs[4*f+i].exp_dpn, (i == 0),
                    $sformatf("vec%0d", 4*f+i));
      end
    end

    // Second strobe during blanking restarts the gap and advances idx.
    digits = 16'h5678;
    blank  = '0;
    dp     = '0;
    do_reset();
    strobe();
    check("restart_first seg", 32'(seg), 32'h00);
    check("restart_first frame_done", 32'(frame_done), 32'h1);
    repeat (4) tick();
    check("restart_mid_gap an", 32'(an), 32'hF);
    step_expect(4'b1101, 7'h78, 1'b1, 1'b0, "restart_d1");

    // Reset while a digit is shown.
    reset = 1'b0;
    tick();
    check_reset_outputs("reset_in_show");
    tick();
    check_reset_outputs("reset_in_show_hold");

    // Randomized strobes against the frame-level model.
    do_reset();
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 2) != 0) begin
        digits = 16'($urandom);
        blank  = 4'($urandom_range(0, 15));
        dp     = 4'($urandom_range(0, 15));
      end
      model_step(e_an, e_seg, e_dpn, e_fd);
      step_expect(e_an, e_seg, e_dpn, e_fd, $sformatf("rand%0d", s));
      repeat ($urandom_range(0, 5)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed 7-segment display scanner for the Nexys3 four-digit display. Consumes the ~763 Hz scan strobe from the display clock divider, samples it in the 100 MHz `clk` domain and steps one digit per strobe rising edge. On each step it drives the active-low anode and cathode lines, inserting a blanking gap between digits to prevent ghosting. Digit values are frame-latched so the display never shows a half-updated value.

## Interface
- `DIGITS`, 4: number of multiplexed digits.
- `BLANK_CYCLES`, 16: `clk` cycles with all anodes off after each step; legal range 1..255.
- `clk`  in  1  100 MHz system clock.
- `reset`  in  1  synchronous, active-low reset.
- `sclk`  in  1  scan strobe from the divider. Treated as asynchronous data, never used as a clock.
- `digits`  in  4*DIGITS  hex value per digit; digit i is `digits[4i+3:4i]`, and digit 0 is rightmost.
- `blank`  in  DIGITS  bit i set forces digit i dark.
- `dp`  in  DIGITS  bit i set lights the decimal point of digit i.
- `an`  out  DIGITS  anode enables, active-low; `an[i]` selects digit i.
- `seg`  out  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- `dp_n`  out  1  decimal-point cathode, active-low.
- `frame_done`  out  1  one-cycle pulse when a new frame is latched.

## Operation
- **Strobe sampling:** `sclk` passes through a 2-flop synchronizer, then a third flop. A step fires on the cycle where the synchronized value is 1 and the delayed value is 0. Falling edges are ignored.
- **Digit index:** `idx` is clog2(DIGITS) bits wide. Reset value is DIGITS-1. Each step sets `idx` to `idx+1`, wrapping from DIGITS-1 to 0.
- **Frame latch:** on a step that wraps to 0, copy `digits`, `blank` and `dp` into shadow registers and pulse `frame_done`. The displayed data comes only from the shadow registers. Because reset sets `idx` to DIGITS-1, the first step after reset latches a frame.
- **Blanking FSM**, two states:
  - BLANK: `an` all 1. Counter loaded with BLANK_CYCLES-1 on the step and decremented each cycle. Move to SHOW on the cycle the counter reaches 0.
  - SHOW: `an[idx]`=0 and all other anode bits 1. Stay in SHOW until the next step, which returns to BLANK.
  - Reset state is BLANK with the counter at 0 and a "no digit yet" flag set. This flag holds the FSM in BLANK, with `an` all 1, until the first step.
- **Step during BLANK:** `idx` advances and the counter reloads. The blanking restarts in full; it is not cumulative.
- **Decode:** hex 0–F to the standard glyph, active-low. Examples: 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, A→7'b0001000, F→7'b0001110.
  - If the shadow blank bit for `idx` is set, `seg`=7'b1111111 and `dp_n`=1.
  - `dp_n` is the inverse of the shadow dp bit for `idx`.
- **Registered outputs:** `an`, `seg`, `dp_n` and `frame_done` are all registered.
- **Reset values:** `an` all 1, `seg`=7'b1111111, `dp_n`=1, `frame_done`=0. Shadow registers are 0 and `blank` shadow is all 1.

## Timing
- **Step latency:** a `sclk` rise presented before clock edge N is detected as a step at edge N+2. The outputs reflect the new `idx` at edge N+3:
  - `an` all 1;
  - `seg` and `dp_n` for the new digit;
  - `frame_done`=1 when the step wrapped to 0.
- **Blanking length:** `an` stays all 1 for exactly BLANK_CYCLES cycles. `an[idx]` goes low on the following cycle.
- **Cathode timing:** `seg` and `dp_n` change only in the first blanking cycle, so cathodes are stable before the anode enables.
- **Input changes:** changes to `digits`, `blank` or `dp` mid-frame have no visible effect until the next wrap to 0.
- **Reset mid-scan:** takes effect on the next edge. All outputs return to their reset values with no partial blanking.
- **Strobe rate:** pulses shorter than 2 `clk` cycles may be missed; the divider strobe is far slower.

## Structure
- **Package `seg_pkg`:**
  - 7-bit glyph constants SEG_0..SEG_F and SEG_OFF (7'b1111111);
  - state typedef {BLANK, SHOW};
  - `hex_to_seg` function.
- **Sub-module `seg_decoder`:** combinational, 4-bit hex in, 7-bit active-low glyph out. Uses `hex_to_seg`.
- **Top-level `seg_scan`:** synchronizer/edge detector, index counter, shadow registers, blanking FSM, output registers.

## Test plan
- **Reset hold:** `reset`=0 for 5 cycles while `sclk` toggles → `an`=4'b1111, `seg`=7'h7F, `dp_n`=1, no `frame_done`.
- **First frame:** `digits`=16'h1234, first `sclk` rise → `frame_done` pulse 3 cycles after the rise and `seg`=SEG_4. Then `an`=4'b1111 for exactly 16 cycles, then `an`=4'b1110.
- **Full scan:** four further strobes → `an` goes 1101 (SEG_3), 1011 (SEG_2), 0111 (SEG_1), then back to 1110 with a second `frame_done`.
- **Frame latch:** change `digits` to 16'hABCD after digit 1 is shown → digits 2 and 3 still show 2 and 1; A–D appear only after the wrap.
- **Blank and dp:** `blank`=4'b0010, `dp`=4'b0100 → digit 1 has `seg`=7'h7F and `dp_n`=1; digit 2 has `dp_n`=0.
- **Edge cases:** a second `sclk` rise during BLANK → `idx` advances and the 16-cycle gap restarts. Reset asserted during SHOW → outputs return to reset values on the next edge.
